// File: rtl/parity_frame_rx.sv
// parity_frame_rx: serial frame receiver with XOR parity check.
// Deserialises frames of start(0) / DATA_W data bits (LSB first) / parity /
// stop(1) from sdi, sampling only when bit_en=1, and flags parity and
// framing errors on the delivered word.
//
// Parameters:
//   DATA_W      data bits per frame (1..32)
//   ODD_PARITY  0 = even parity, 1 = odd parity
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bit_en      per-bit sample strobe
//   sdi         serial data in (idle high)
//   err_clr     clears the sticky error flags (PARITY_RX_STICKY_ERR_EN only)
//   data_out    last received data word
//   data_valid  one-cycle pulse when data_out/flags update
//   parity_err  parity mismatch on the last frame (sticky with the macro)
//   frame_err   stop bit was 0 on the last frame (sticky with the macro)
//   busy        frame in progress
// Build option: define PARITY_RX_STICKY_ERR_EN for sticky error flags.
module parity_frame_rx #(
    parameter int unsigned DATA_W     = 8,
    parameter bit          ODD_PARITY = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              sdi,
`ifdef PARITY_RX_STICKY_ERR_EN
    input  logic              err_clr,
`endif
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    bit_cnt;
    logic [DATA_W-1:0]   shreg;
    logic                acc;
    logic                perr_lat;
    logic                last_bit;

    assign last_bit = (bit_cnt == CNT_W'(DATA_W - 1));
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (bit_en) begin
            case (state)
                IDLE:    if (!sdi) state_nxt = DATA;
                DATA:    if (last_bit) state_nxt = PARITY;
                PARITY:  state_nxt = STOP;
                STOP:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            acc        <= 1'b0;
            perr_lat   <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
`ifdef PARITY_RX_STICKY_ERR_EN
            if (err_clr) begin
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
            end
`endif
            if (bit_en) begin
                case (state)
                    IDLE: begin
                        if (!sdi) begin
                            bit_cnt <= '0;
                            acc     <= ODD_PARITY;
                        end
                    end
                    DATA: begin
                        // bit k of the frame lands directly in position k
                        for (int unsigned i = 0; i < DATA_W; i++) begin
                            if (bit_cnt == CNT_W'(i)) shreg[i] <= sdi;
                        end
                        acc     <= acc ^ sdi;
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                    PARITY: begin
                        perr_lat <= acc ^ sdi;
                    end
                    STOP: begin
                        data_out   <= shreg;
                        data_valid <= 1'b1;
`ifdef PARITY_RX_STICKY_ERR_EN
                        // a new error overrides a simultaneous err_clr
                        parity_err <= perr_lat | (parity_err & ~err_clr);
                        frame_err  <= ~sdi | (frame_err & ~err_clr);
`else
                        parity_err <= perr_lat;
                        frame_err  <= ~sdi;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_parity_frame_rx.sv
// tb_parity_frame_rx: directed frames into an even-parity and an odd-parity
// receiver sharing the same serial stream; a frame-level model predicts
// every output and is compared each cycle, with literal spot checks.
module tb_parity_frame_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       bit_en;
    logic       sdi;
    logic       err_clr;
    logic [7:0] data_e, data_o;
    logic       valid_e, valid_o, perr_e, perr_o, ferr_e, ferr_o, busy_e, busy_o;

    int errors = 0;
    int checks = 0;

    // frame-level model state
    logic [7:0] exp_data;
    logic       exp_valid, exp_perr_e, exp_perr_o, exp_ferr, exp_busy;

    always #5 clk = ~clk;

    parity_frame_rx #(.DATA_W(8), .ODD_PARITY(1'b0)) dut_e (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .sdi(sdi),
`ifdef PARITY_RX_STICKY_ERR_EN
        .err_clr(err_clr),
`endif
        .data_out(data_e), .data_valid(valid_e), .parity_err(perr_e),
        .frame_err(ferr_e), .busy(busy_e)
    );

    parity_frame_rx #(.DATA_W(8), .ODD_PARITY(1'b1)) dut_o (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .sdi(sdi),
`ifdef PARITY_RX_STICKY_ERR_EN
        .err_clr(err_clr),
`endif
        .data_out(data_o), .data_valid(valid_o), .parity_err(perr_o),
        .frame_err(ferr_o), .busy(busy_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("e.data_out",   32'(data_e),  32'(exp_data));
        chk("e.data_valid", 32'(valid_e), 32'(exp_valid));
        chk("e.parity_err", 32'(perr_e),  32'(exp_perr_e));
        chk("e.frame_err",  32'(ferr_e),  32'(exp_ferr));
        chk("e.busy",       32'(busy_e),  32'(exp_busy));
        chk("o.data_out",   32'(data_o),  32'(exp_data));
        chk("o.data_valid", 32'(valid_o), 32'(exp_valid));
        chk("o.parity_err", 32'(perr_o),  32'(exp_perr_o));
        chk("o.frame_err",  32'(ferr_o),  32'(exp_ferr));
        chk("o.busy",       32'(busy_o),  32'(exp_busy));
    end

    task automatic model_reset();
        exp_data   = '0;
        exp_valid  = 1'b0;
        exp_perr_e = 1'b0;
        exp_perr_o = 1'b0;
        exp_ferr   = 1'b0;
        exp_busy   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        exp_valid = 1'b0;
    endtask

    task automatic strobe(input logic b);
        bit_en = 1'b1;
        sdi    = b;
        tick();
        bit_en = 1'b0;
    endtask

    task automatic gap(input int unsigned maxgap);
        int unsigned g;
        g = (maxgap == 0) ? 0 : $urandom_range(maxgap, 0);
        repeat (g) begin
            sdi = 1'($urandom_range(1, 0));
            tick();
        end
    endtask

    // start, 8 data bits LSB first, parity bit p, stop bit s
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input int unsigned maxgap);
        logic [10:0] bits;
        logic        ones_odd;
        bits = {s, p, d, 1'b0};
        ones_odd = ^{d, p};
        for (int i = 0; i < 11; i++) begin
            strobe(bits[i]);
            if (i == 0) exp_busy = 1'b1;
            if (i < 10) gap(maxgap);
        end
        exp_busy  = 1'b0;
        exp_valid = 1'b1;
        exp_data  = d;
`ifdef PARITY_RX_STICKY_ERR_EN
        exp_perr_e = exp_perr_e | ones_odd;
        exp_perr_o = exp_perr_o | ~ones_odd;
        exp_ferr   = exp_ferr | ~s;
`else
        exp_perr_e = ones_odd;
        exp_perr_o = ~ones_odd;
        exp_ferr   = ~s;
`endif
        sdi = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        bit_en  = 1'b0;
        sdi     = 1'b1;
        err_clr = 1'b0;
        model_reset();
        repeat (3) tick();
        chk("reset.data_out", 32'(data_e), 32'h0);
        chk("reset.busy",     32'(busy_e), 32'h0);
        rst_n = 1'b1;
        tick();

        // clean even frame
        send_frame(8'hA5, 1'b0, 1'b1, 0);
        chk("a5.data",  32'(data_e),  32'hA5);
        chk("a5.valid", 32'(valid_e), 32'h1);
        chk("a5.perr",  32'(perr_e),  32'h0);
        chk("a5.ferr",  32'(ferr_e),  32'h0);
        chk("a5.operr", 32'(perr_o),  32'h1);
        tick();
        chk("a5.valid_drop", 32'(valid_e), 32'h0);

        // bad parity, then a clean frame
        send_frame(8'hA5, 1'b1, 1'b1, 0);
        chk("a5p1.data", 32'(data_e), 32'hA5);
        chk("a5p1.perr", 32'(perr_e), 32'h1);
        chk("a5p1.ferr", 32'(ferr_e), 32'h0);
        tick();
        send_frame(8'h3C, 1'b0, 1'b1, 0);
        chk("3c.data", 32'(data_e), 32'h3C);
`ifdef PARITY_RX_STICKY_ERR_EN
        chk("3c.perr_sticky", 32'(perr_e), 32'h1);
`else
        chk("3c.perr", 32'(perr_e), 32'h0);
`endif

        // framing error, new frame started on the very next strobe
        send_frame(8'h0F, 1'b0, 1'b0, 0);
        chk("0f.data", 32'(data_e), 32'h0F);
        chk("0f.ferr", 32'(ferr_e), 32'h1);
        send_frame(8'h66, 1'b0, 1'b1, 0);
        chk("66.data", 32'(data_e), 32'h66);
        tick();

        // odd parity receiver
        send_frame(8'h01, 1'b0, 1'b1, 0);
        chk("01p0.operr", 32'(perr_o), 32'h0);
        chk("01p0.eperr", 32'(perr_e), 32'h1);
        tick();
        send_frame(8'h01, 1'b1, 1'b1, 0);
        chk("01p1.operr", 32'(perr_o), 32'h1);
        tick();

        // strobe gaps with sdi noise, then back-to-back frame
        send_frame(8'h5A, 1'b0, 1'b1, 5);
        chk("5a.data", 32'(data_e), 32'h5A);
`ifndef PARITY_RX_STICKY_ERR_EN
        chk("5a.perr", 32'(perr_e), 32'h0);
        chk("5a.ferr", 32'(ferr_e), 32'h0);
`endif
        send_frame(8'hC3, 1'b0, 1'b1, 0);
        chk("c3.data",  32'(data_e),  32'hC3);
        chk("c3.valid", 32'(valid_e), 32'h1);
        tick();

        // reset mid-frame after 4 data bits
        strobe(1'b0);
        exp_busy = 1'b1;
        for (int i = 0; i < 4; i++) strobe(1'(i & 1));
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst.data",  32'(data_e),  32'h0);
        chk("rst.busy",  32'(busy_e),  32'h0);
        chk("rst.valid", 32'(valid_e), 32'h0);
        chk("rst.perr",  32'(perr_e),  32'h0);
        chk("rst.ferr",  32'(ferr_e),  32'h0);
        tick();
        rst_n = 1'b1;
        sdi   = 1'b1;
        tick();
        send_frame(8'h81, 1'b0, 1'b1, 0);
        chk("81.data", 32'(data_e), 32'h81);
        chk("81.perr", 32'(perr_e), 32'h0);
        tick();

`ifdef PARITY_RX_STICKY_ERR_EN
        send_frame(8'hA5, 1'b1, 1'b1, 0);
        tick();
        send_frame(8'h3C, 1'b0, 1'b1, 0);
        chk("sticky.hold", 32'(perr_e), 32'h1);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr    = 1'b0;
        exp_perr_e = 1'b0;
        exp_perr_o = 1'b0;
        exp_ferr   = 1'b0;
        chk("sticky.clr", 32'(perr_e), 32'h0);
        tick();
`endif

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/parity_frame_rx.md
# parity_frame_rx

Serial frame receiver that checks an XOR-computed parity bit: it deserialises start/data/parity/stop frames from a single serial input and flags parity and framing errors. It is the checking end of the team's XOR parity generation path and sits between a bit-timing source, which supplies a per-bit sample strobe, and parallel consumer logic.

## Interface
- `DATA_W`, default 8: number of data bits per frame, LSB first; legal range 1..32.
- `ODD_PARITY`, default 0: 0 = even parity, 1 = odd parity.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `bit_en`  in  1  sample strobe; `sdi` is consumed only in cycles where `bit_en`=1.
- `sdi`  in  1  serial data in; idle level 1.
- `data_out`  out  `DATA_W`  last received data word.
- `data_valid`  out  1  one-cycle pulse when `data_out`/flags update.
- `parity_err`  out  1  parity mismatch on the last frame.
- `frame_err`  out  1  stop bit was 0 on the last frame.
- `busy`  out  1  high while a frame is in progress (state ≠ IDLE).
- `err_clr`  in  1  present only with `PARITY_RX_STICKY_ERR_EN`, see Configuration.

## Operation
- FSM states: IDLE, DATA, PARITY, STOP.
- All transitions require `bit_en`=1. With `bit_en`=0 the FSM, counters and outputs hold, except that `data_valid` drops.
- **IDLE:**
  - `sdi`=0 → DATA; bit count cleared; parity accumulator loaded with `ODD_PARITY`.
  - `sdi`=1 → stay in IDLE.
- **DATA:**
  - Shift `sdi` into the shift register LSB first: bit k lands in position k.
  - Accumulator ^= `sdi`.
  - After the `DATA_W`-th bit → PARITY.
- **PARITY:**
  - Latch the error term accumulator ^ `sdi`; 1 means error.
  - → STOP.
- **STOP:**
  - Register `data_out` ← shift register.
  - `parity_err` ← latched error term.
  - `frame_err` ← ~`sdi`.
  - `data_valid` ← 1.
  - → IDLE regardless of `sdi`.
- A frame with an error still delivers data and asserts `data_valid`; the flags qualify it.
- `data_out`, `parity_err` and `frame_err` hold until the next STOP sample.
- Bit counter width is clog2(`DATA_W`+1); the counter never wraps within a frame.

## Timing
- Reset values: `data_out`=0, `data_valid`=0, `parity_err`=0, `frame_err`=0, `busy`=0; FSM in IDLE.
- `data_valid` rises in the cycle after the clock edge that samples the stop bit. It is high for exactly one cycle.
- `busy` rises in the cycle after the start bit is sampled. It falls in the same cycle that `data_valid` rises.
- Minimum frame length is `DATA_W`+3 `bit_en` strobes.
- A start bit may be sampled on the very next `bit_en` after STOP, so back-to-back frames are legal.
- `bit_en` asserted on consecutive cycles is legal; gaps of any length are legal.
- Reset asserted mid-frame:
  - Frame discarded; no `data_valid`.
  - All outputs go to their reset values immediately (asynchronously).
- `sdi` toggling while `bit_en`=0 has no effect.

## Configuration
- `PARITY_RX_STICKY_ERR_EN` defined:
  - Adds the `err_clr` input.
  - `parity_err`/`frame_err` are set by a faulty frame and stay set across later clean frames.
  - They clear only on `err_clr`=1 or reset.
  - If `err_clr` and a new error occur in the same cycle, the set wins.
- `PARITY_RX_STICKY_ERR_EN` undefined:
  - No `err_clr` port.
  - Flags reflect only the most recent frame, as described in Operation.

## Test plan
- `DATA_W`=8, even parity; send start 0, data 0xA5, parity 0, stop 1 → `data_out`=0xA5, one-cycle `data_valid`, `parity_err`=0, `frame_err`=0.
- Same frame with parity bit 1 → `data_out`=0xA5, `parity_err`=1, `frame_err`=0; a following clean frame 0x3C → `parity_err`=0 (macro off).
- Frame 0x0F with stop bit 0 → `frame_err`=1; next `bit_en` with `sdi`=0 starts a new frame.
- `ODD_PARITY`=1; data 0x01, parity 0 → no error; data 0x01, parity 1 → `parity_err`=1.
- Frame 0x5A delivered with random 0–5 cycle `bit_en` gaps and `sdi` toggling in the gaps → `data_out`=0x5A, no errors. A second frame 0xC3 back-to-back → two `data_valid` pulses.
- Reset pulse after 4 data bits → all outputs 0, no `data_valid`; a subsequent 0x81 frame is received correctly. With the macro on, a sticky error holds across a clean frame until `err_clr`.
